// File: rtl/axi_defines.sv
// axi_defines: AXI burst/response encodings and FSM state types shared by the SRAM slave.
package axi_defines;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
endpackage

// File: rtl/axi_sram_addr_gen.sv
// axi_sram_addr_gen: next burst address, SRAM word index and legality check for one channel.
module axi_sram_addr_gen
  import axi_defines::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int STRB_WIDTH = 8,
  parameter int MEM_DEPTH = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [2:0]                   size,
  input  logic [1:0]                   burst,
  output logic [ADDR_WIDTH-1:0]        next_addr,
  output logic [$clog2(MEM_DEPTH)-1:0] word,
  output logic                         err
);
  localparam int OFF_W = $clog2(STRB_WIDTH);
  logic [ADDR_WIDTH-1:0] off;
  assign off = addr - BASE_ADDR;
  assign word = off[OFF_W +: $clog2(MEM_DEPTH)];
  assign err = addr < BASE_ADDR || off >= ADDR_WIDTH'(MEM_DEPTH * STRB_WIDTH) ||
               !(burst == BURST_FIXED || burst == BURST_INCR) || size > 3'(OFF_W);
  assign next_addr = burst == BURST_FIXED ? addr : addr + (ADDR_WIDTH'(1) << size);
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave mapping a 1-cycle-latency single-port SRAM; independent read/write FSMs
// share the SRAM port through a round-robin arbiter.
module axi_sram_slave
  import axi_defines::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  input  logic [7:0]                   S_AXI_ARLEN,
  input  logic [ID_WIDTH-1:0]          S_AXI_ARID,
  input  logic [2:0]                   S_AXI_ARSIZE,
  input  logic [1:0]                   S_AXI_ARBURST,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic [ID_WIDTH-1:0]          S_AXI_RID,
  output logic                         S_AXI_RLAST,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic                         S_AXI_AWVALID,
  input  logic [7:0]                   S_AXI_AWLEN,
  input  logic [ID_WIDTH-1:0]          S_AXI_AWID,
  input  logic [2:0]                   S_AXI_AWSIZE,
  input  logic [1:0]                   S_AXI_AWBURST,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [STRB_WIDTH-1:0]        S_AXI_WSTRB,
  input  logic                         S_AXI_WLAST,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic [ID_WIDTH-1:0]          S_AXI_BID,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  output logic                         o_sram_en,
  output logic                         o_sram_we,
  output logic [$clog2(MEM_DEPTH)-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0]        o_sram_wdata,
  output logic [STRB_WIDTH-1:0]        o_sram_wstrb,
  input  logic [DATA_WIDTH-1:0]        i_sram_rdata
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  rd_state_t r_state;
  wr_state_t w_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_next, w_addr, w_next;
  logic [IDX_W-1:0] r_word, w_word;
  logic [7:0] r_len, r_beat, w_len;
  logic [8:0] w_beat;
  logic [2:0] r_size, w_size;
  logic [1:0] r_burst, w_burst;
  logic r_err, w_aerr, w_err, r_pend;
  logic last_grant, rd_req, wr_req, rd_gnt, wr_gnt, wr_en;

  axi_sram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH), .MEM_DEPTH(MEM_DEPTH),
    .BASE_ADDR(BASE_ADDR)) u_rd_gen (.addr(r_addr), .size(r_size), .burst(r_burst),
    .next_addr(r_next), .word(r_word), .err(r_err));
  axi_sram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH), .MEM_DEPTH(MEM_DEPTH),
    .BASE_ADDR(BASE_ADDR)) u_wr_gen (.addr(w_addr), .size(w_size), .burst(w_burst),
    .next_addr(w_next), .word(w_word), .err(w_aerr));

  // last_grant=1 means the read side won last, so the write side wins the next tie
  assign rd_req = i_rst_n && r_state == R_ISSUE && !r_err;
  assign wr_req = i_rst_n && w_state == W_DATA && S_AXI_WVALID;
  assign rd_gnt = rd_req && (!wr_req || !last_grant);
  assign wr_gnt = wr_req && !rd_gnt;
  assign wr_en = wr_gnt && !w_aerr && w_beat <= {1'b0, w_len};
  assign S_AXI_WREADY = wr_gnt;
  assign o_sram_en = rd_gnt || wr_en;
  assign o_sram_we = wr_en;
  assign o_sram_addr = wr_en ? w_word : r_word;
  assign o_sram_wdata = S_AXI_WDATA;
  assign o_sram_wstrb = wr_en ? S_AXI_WSTRB : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) last_grant <= 1'b1;
    else if (rd_gnt || wr_gnt) last_grant <= rd_gnt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
      S_AXI_RLAST <= 1'b0;
      S_AXI_RID <= '0;
      r_pend <= 1'b0;
      r_addr <= '0;
      r_len <= '0;
      r_beat <= '0;
      r_size <= '0;
      r_burst <= BURST_FIXED;
    end else begin
      case (r_state)
        R_IDLE: begin
          S_AXI_ARREADY <= !(S_AXI_ARVALID && S_AXI_ARREADY);
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            r_addr <= S_AXI_ARADDR;
            r_len <= S_AXI_ARLEN;
            S_AXI_RID <= S_AXI_ARID;
            r_size <= S_AXI_ARSIZE;
            r_burst <= S_AXI_ARBURST;
            r_beat <= '0;
            r_state <= R_ISSUE;
          end
        end
        R_ISSUE: if (r_err || rd_gnt) begin
          r_pend <= 1'b1;
          r_state <= R_DATA;
        end
        R_DATA: begin
          // r_pend marks the cycle the SRAM output is valid and gets captured
          if (r_pend) begin
            r_pend <= 1'b0;
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA <= r_err ? '0 : i_sram_rdata;
            S_AXI_RRESP <= r_err ? RESP_SLVERR : RESP_OKAY;
            S_AXI_RLAST <= r_beat == r_len;
          end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            if (S_AXI_RLAST) begin
              S_AXI_ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_beat <= r_beat + 8'd1;
              r_state <= R_ISSUE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      w_state <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= RESP_OKAY;
      S_AXI_BID <= '0;
      w_addr <= '0;
      w_len <= '0;
      w_beat <= '0;
      w_size <= '0;
      w_burst <= BURST_FIXED;
      w_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          S_AXI_AWREADY <= !(S_AXI_AWVALID && S_AXI_AWREADY);
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            w_addr <= S_AXI_AWADDR;
            w_len <= S_AXI_AWLEN;
            S_AXI_BID <= S_AXI_AWID;
            w_size <= S_AXI_AWSIZE;
            w_burst <= S_AXI_AWBURST;
            w_beat <= '0;
            w_err <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: if (wr_gnt) begin
          w_addr <= w_next;
          w_beat <= w_beat + 9'(w_beat != '1);
          w_err <= w_err || w_aerr;
          if (S_AXI_WLAST) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP <= (w_err || w_aerr || w_beat != {1'b0, w_len}) ? RESP_SLVERR : RESP_OKAY;
            w_state <= W_RESP;
          end
        end
        W_RESP: if (S_AXI_BREADY) begin
          S_AXI_BVALID <= 1'b0;
          S_AXI_AWREADY <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule
